// File: rtl/keypad_pkg.sv
// Shared keypad geometry, key-vector type and small helpers for the 4x4 matrix scanner.
package keypad_pkg;

    localparam int unsigned KP_ROWS  = 4;
    localparam int unsigned KP_COLS  = 4;
    localparam int unsigned KP_KEYS  = KP_ROWS * KP_COLS;
    localparam int unsigned KP_ROW_W = 2;

    typedef logic [KP_KEYS-1:0] key_vec_t;
    typedef logic [KP_COLS-1:0] col_vec_t;

    function automatic int unsigned key_idx(input int unsigned row, input int unsigned col);
        return row * KP_COLS + col;
    endfunction

    function automatic logic [KP_ROWS-1:0] row_onecold(input logic [KP_ROW_W-1:0] row);
        return ~(KP_ROWS'(1) << row);
    endfunction

    // True when two row snapshots have at least two pressed columns in common
    function automatic logic shares_two(input col_vec_t a, input col_vec_t b);
        col_vec_t m;
        m = a & b;
        return (m & (m - col_vec_t'(1))) != '0;
    endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad matrix lines plus the debounced key-vector outputs toward the game core.
interface keypad_scan_if;
    import keypad_pkg::*;

    logic [KP_COLS-1:0] col_n;
    logic [KP_ROWS-1:0] row_n;
    key_vec_t           key;
    key_vec_t           key_press;
    key_vec_t           key_release;
    logic               frame_done;

    modport master (
        input  col_n,
        output row_n, key, key_press, key_release, frame_done
    );

    modport slave (
        output col_n,
        input  row_n, key, key_press, key_release, frame_done
    );

endinterface

// File: rtl/keypad_debounce.sv
// Frame-granularity debouncer: a key vector is accepted after DEBOUNCE_FRAMES identical frames.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_FRAMES = 5
) (
    input  logic     clk,
    input  logic     rst,
    input  key_vec_t i_frame,
    input  logic     i_valid,
    output key_vec_t o_key,
    output key_vec_t o_key_press,
    output key_vec_t o_key_release
);

    localparam int unsigned        CNT_W   = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DEBOUNCE_FRAMES);

    key_vec_t         r_cand;
    key_vec_t         r_key;
    key_vec_t         r_press;
    key_vec_t         r_release;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_accept;

    // A differing frame restarts the run at 1; a matching one extends it up to saturation
    always_comb begin
        w_cnt_nxt = CNT_W'(1);
        if (i_frame == r_cand) begin
            w_cnt_nxt = (r_cnt < CNT_MAX) ? r_cnt + CNT_W'(1) : r_cnt;
        end
    end

    assign w_accept = (w_cnt_nxt == CNT_MAX) && (i_frame != r_key);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cand    <= '0;
            r_cnt     <= '0;
            r_key     <= '0;
            r_press   <= '0;
            r_release <= '0;
        end else begin
            r_press   <= '0;
            r_release <= '0;
            if (i_valid) begin
                r_cand <= i_frame;
                r_cnt  <= w_cnt_nxt;
                if (w_accept) begin
                    r_key     <= i_frame;
                    r_press   <= i_frame & ~r_key;
                    r_release <= r_key & ~i_frame;
                end
            end
        end
    end

    assign o_key         = r_key;
    assign o_key_press   = r_press;
    assign o_key_release = r_release;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad row scanner with column synchroniser, frame assembly and debounce.
// Define KEYPAD_GHOST_REJECT_EN to drop frames where two rows share two or more pressed columns.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_CYCLES     = 1000,
    parameter int unsigned DEBOUNCE_FRAMES = 5
) (
    input  logic          clk,
    input  logic          rst,
    keypad_scan_if.master kp
);

    localparam int unsigned           SLOT_W    = $clog2(SCAN_CYCLES);
    localparam logic [SLOT_W-1:0]     SLOT_LAST = SLOT_W'(SCAN_CYCLES - 1);
    localparam logic [KP_ROW_W-1:0]   ROW_LAST  = KP_ROW_W'(KP_ROWS - 1);
    localparam int unsigned           SHADOW_W  = KP_KEYS - KP_COLS;

    logic [KP_COLS-1:0]  r_col_s1;
    logic [KP_COLS-1:0]  r_col_s2;
    logic [SLOT_W-1:0]   r_slot;
    logic [KP_ROW_W-1:0] r_row;
    logic [KP_ROWS-1:0]  r_row_n;
    logic [SHADOW_W-1:0] r_shadow;
    key_vec_t            r_frame;
    logic                r_frame_done;
    col_vec_t            w_cols;
    logic                w_slot_end;
    logic                w_ghost;
    logic                w_frame_valid;

    assign w_cols     = ~r_col_s2;
    assign w_slot_end = (r_slot == SLOT_LAST);

    // Columns idle high, so the synchroniser resets to "nothing pressed"
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col_s1 <= '1;
            r_col_s2 <= '1;
        end else begin
            r_col_s1 <= kp.col_n;
            r_col_s2 <= r_col_s1;
        end
    end

    // Sample at the last cycle of each row slot; the last row completes the frame
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot       <= '0;
            r_row        <= '0;
            r_row_n      <= row_onecold('0);
            r_shadow     <= '0;
            r_frame      <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_slot_end) begin
                r_slot  <= '0;
                r_row   <= r_row + KP_ROW_W'(1);
                r_row_n <= row_onecold(r_row + KP_ROW_W'(1));
                for (int r = 0; r < int'(KP_ROWS) - 1; r++) begin
                    if (r_row == KP_ROW_W'(r)) r_shadow[r*KP_COLS +: KP_COLS] <= w_cols;
                end
                if (r_row == ROW_LAST) begin
                    r_frame      <= {w_cols, r_shadow};
                    r_frame_done <= 1'b1;
                end
            end else begin
                r_slot <= r_slot + SLOT_W'(1);
            end
        end
    end

`ifdef KEYPAD_GHOST_REJECT_EN
    always_comb begin
        w_ghost = 1'b0;
        for (int a = 0; a < int'(KP_ROWS); a++) begin
            for (int b = a + 1; b < int'(KP_ROWS); b++) begin
                if (shares_two(r_frame[a*KP_COLS +: KP_COLS], r_frame[b*KP_COLS +: KP_COLS])) begin
                    w_ghost = 1'b1;
                end
            end
        end
    end
`else
    assign w_ghost = 1'b0;
`endif

    assign w_frame_valid = r_frame_done & ~w_ghost;

    keypad_debounce #(
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
    ) u_debounce (
        .clk           (clk),
        .rst           (rst),
        .i_frame       (r_frame),
        .i_valid       (w_frame_valid),
        .o_key         (kp.key),
        .o_key_press   (kp.key_press),
        .o_key_release (kp.key_release)
    );

    assign kp.row_n      = r_row_n;
    assign kp.frame_done = r_frame_done;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: matrix keypad model, directed scenarios and a randomized frame sequence
// checked against a sliding-window debounce model.
module tb_keypad_scan;
    import keypad_pkg::*;

    localparam int unsigned SC = 8;
    localparam int unsigned DF = 3;
    localparam int unsigned FRAME = 4 * SC;
    localparam key_vec_t    KEY21 = key_vec_t'(1) << key_idx(2, 1);

    logic     clk;
    logic     rst;
    key_vec_t kp_keys;
    logic [3:0] w_col_n;
    int       total;
    int       bad;

    key_vec_t hist[$];
    key_vec_t m_key, m_press, m_rel;

    keypad_scan_if kp();

    keypad_scan #(.SCAN_CYCLES(SC), .DEBOUNCE_FRAMES(DF)) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A pressed key pulls its column low while its row is driven low
    always_comb begin
        w_col_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (kp_keys[r*4+c] && !kp.row_n[r]) w_col_n[c] = 1'b0;
    end
    assign kp.col_n = w_col_n;

    function automatic bit is_ghost(input key_vec_t f);
        for (int a = 0; a < 4; a++)
            for (int b = a + 1; b < 4; b++) begin
                int n = 0;
                for (int c = 0; c < 4; c++) if (f[a*4+c] && f[b*4+c]) n++;
                if (n >= 2) return 1'b1;
            end
        return 1'b0;
    endfunction

    // Key takes a frame value once the last DF accepted frames are all equal to it
    task automatic model_push(input key_vec_t f);
        bit same;
        m_press = '0;
        m_rel   = '0;
`ifdef KEYPAD_GHOST_REJECT_EN
        if (is_ghost(f)) return;
`endif
        hist.push_back(f);
        if (hist.size() > DF) void'(hist.pop_front());
        if (hist.size() == DF) begin
            same = 1'b1;
            foreach (hist[i]) if (hist[i] != f) same = 1'b0;
            if (same && f != m_key) begin
                m_press = f & ~m_key;
                m_rel   = m_key & ~f;
                m_key   = f;
            end
        end
    endtask

    // Leaves the bench at the negedge of the first cycle after reset
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        hist.delete();
        m_key = '0; m_press = '0; m_rel = '0;
    endtask

    task automatic wait_fd(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < int'(2 * FRAME); i++) begin
            @(negedge clk);
            if (kp.frame_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int fd_cnt = 0;
        int nz = 0;
        logic [3:0] exp_row;
        kp_keys = '0;
        do_reset();
        total++; if (kp.row_n !== 4'b1110) begin bad++; $display("FAIL reset_row_n got=%b exp=1110", kp.row_n); end
        total++; if (kp.key !== '0) begin bad++; $display("FAIL reset_key got=%h exp=0000", kp.key); end
        total++; if (kp.key_press !== '0) begin bad++; $display("FAIL reset_press got=%h exp=0000", kp.key_press); end
        total++; if (kp.key_release !== '0) begin bad++; $display("FAIL reset_release got=%h exp=0000", kp.key_release); end
        total++; if (kp.frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b exp=0", kp.frame_done); end
        for (int c = 1; c <= 96; c++) begin
            @(negedge clk);
            if (kp.frame_done === 1'b1) fd_cnt++;
            if (kp.key !== '0 || kp.key_press !== '0 || kp.key_release !== '0) nz++;
            if (c % 8 == 0) begin
                exp_row = ~(4'b0001 << ((c / 8) % 4));
                total++; if (kp.row_n !== exp_row) begin bad++; $display("FAIL scan_row_n cyc=%0d got=%b exp=%b", c, kp.row_n, exp_row); end
            end
        end
        total++; if (fd_cnt != 3) begin bad++; $display("FAIL idle_frame_done_count got=%0d exp=3", fd_cnt); end
        total++; if (nz != 0) begin bad++; $display("FAIL idle_outputs_nonzero got=%0d exp=0", nz); end
    endtask

    task automatic test_hold();
        int pc = 0;
        kp_keys = KEY21;
        do_reset();
        for (int c = 1; c <= 98; c++) begin
            @(negedge clk);
            if (kp.key_press !== '0) pc++;
            if (c == 64) begin total++; if (kp.frame_done !== 1'b1) begin bad++; $display("FAIL hold_fd2 got=%b exp=1", kp.frame_done); end end
            if (c == 65) begin total++; if (kp.key !== '0) begin bad++; $display("FAIL hold_key_after_2 got=%h exp=0000", kp.key); end end
            if (c == 96) begin total++; if (kp.key !== '0) begin bad++; $display("FAIL hold_key_at_fd3 got=%h exp=0000", kp.key); end end
            if (c == 97) begin
                total++; if (kp.key !== KEY21) begin bad++; $display("FAIL hold_key got=%h exp=%h", kp.key, KEY21); end
                total++; if (kp.key_press !== KEY21) begin bad++; $display("FAIL hold_press got=%h exp=%h", kp.key_press, KEY21); end
            end
        end
        total++; if (pc != 1) begin bad++; $display("FAIL hold_press_cycles got=%0d exp=1", pc); end
    endtask

    task automatic test_bounce();
        bit ok;
        int first = -1;
        int pc = 0, rc = 0;
        key_vec_t pv = '0;
        kp_keys = '0;
        do_reset();
        wait_fd(ok);
        total++; if (!ok) begin bad++; $display("FAIL bounce_wait_fd got=timeout exp=pulse"); end
        for (int c = 0; c < 170; c++) begin
            if (c > 0) @(negedge clk);
            if (kp.key === KEY21 && first < 0) begin first = c; pv = kp.key_press; end
            if (kp.key_press !== '0) pc++;
            if (kp.key_release !== '0) rc++;
            if (c < 60 && c % 10 == 0) kp_keys = ((c / 10) % 2 == 0) ? KEY21 : '0;
            if (c == 60) kp_keys = KEY21;
        end
        total++; if (first != 161) begin bad++; $display("FAIL bounce_key_cycle got=%0d exp=161", first); end
        total++; if (pv !== KEY21) begin bad++; $display("FAIL bounce_press_val got=%h exp=%h", pv, KEY21); end
        total++; if (pc != 1) begin bad++; $display("FAIL bounce_press_count got=%0d exp=1", pc); end
        total++; if (rc != 0) begin bad++; $display("FAIL bounce_release_count got=%0d exp=0", rc); end
    endtask

    task automatic test_release();
        bit ok;
        int pc = 0, rc = 0;
        wait_fd(ok);
        total++; if (!ok) begin bad++; $display("FAIL release_wait_fd got=timeout exp=pulse"); end
        kp_keys = '0;
        for (int c = 1; c <= 98; c++) begin
            @(negedge clk);
            if (kp.key_press !== '0) pc++;
            if (kp.key_release !== '0) rc++;
            if (c == 96) begin total++; if (kp.key !== KEY21) begin bad++; $display("FAIL release_key_held got=%h exp=%h", kp.key, KEY21); end end
            if (c == 97) begin
                total++; if (kp.key !== '0) begin bad++; $display("FAIL release_key got=%h exp=0000", kp.key); end
                total++; if (kp.key_release !== KEY21) begin bad++; $display("FAIL release_pulse got=%h exp=%h", kp.key_release, KEY21); end
            end
        end
        total++; if (rc != 1) begin bad++; $display("FAIL release_pulse_count got=%0d exp=1", rc); end
        total++; if (pc != 0) begin bad++; $display("FAIL release_press_count got=%0d exp=0", pc); end
    endtask

    task automatic test_reset_mid();
        int rc = 0, pc = 0, guard = 0;
        kp_keys = KEY21;
        do_reset();
        repeat (100) @(negedge clk);
        total++; if (kp.key !== KEY21) begin bad++; $display("FAIL rmid_preset_key got=%h exp=%h", kp.key, KEY21); end
        while (kp.row_n !== 4'b1011 && guard < int'(2 * FRAME)) begin @(negedge clk); guard++; end
        total++; if (kp.row_n !== 4'b1011) begin bad++; $display("FAIL rmid_find_row2 got=%b exp=1011", kp.row_n); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (kp.key !== '0) begin bad++; $display("FAIL rmid_key got=%h exp=0000", kp.key); end
        total++; if (kp.row_n !== 4'b1110) begin bad++; $display("FAIL rmid_row_n got=%b exp=1110", kp.row_n); end
        for (int c = 1; c <= 98; c++) begin
            @(negedge clk);
            if (kp.key_release !== '0) rc++;
            if (kp.key_press !== '0) pc++;
            if (c == 96) begin total++; if (kp.key !== '0) begin bad++; $display("FAIL rmid_key_fd3 got=%h exp=0000", kp.key); end end
            if (c == 97) begin total++; if (kp.key !== KEY21) begin bad++; $display("FAIL rmid_key_back got=%h exp=%h", kp.key, KEY21); end end
        end
        total++; if (rc != 0) begin bad++; $display("FAIL rmid_release_count got=%0d exp=0", rc); end
        total++; if (pc != 1) begin bad++; $display("FAIL rmid_press_count got=%0d exp=1", pc); end
    endtask

    task automatic test_ghost();
        int fd_cnt = 0;
        key_vec_t exp_key;
`ifdef KEYPAD_GHOST_REJECT_EN
        exp_key = '0;
`else
        exp_key = 16'h0033;
`endif
        kp_keys = 16'h0033;
        do_reset();
        for (int c = 1; c <= 98; c++) begin
            @(negedge clk);
            if (kp.frame_done === 1'b1) fd_cnt++;
        end
        total++; if (fd_cnt != 3) begin bad++; $display("FAIL ghost_frame_done got=%0d exp=3", fd_cnt); end
        total++; if (kp.key !== exp_key) begin bad++; $display("FAIL ghost_key got=%h exp=%h", kp.key, exp_key); end
    endtask

    task automatic test_random();
        bit ok;
        int sel;
        key_vec_t cur = '0;
        kp_keys = '0;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            wait_fd(ok);
            total++; if (!ok) begin bad++; $display("FAIL rand_wait_fd frame=%0d got=timeout exp=pulse", i); end
            model_push(cur);
            sel = int'($urandom_range(0, 9));
            if (sel >= 5) begin
                if (sel < 8) cur = 16'($urandom & $urandom & $urandom);
                else if (sel == 8) cur = 16'h0505;
                else cur = '0;
            end
            kp_keys = cur;
            @(negedge clk);
            total++; if (kp.key !== m_key) begin bad++; $display("FAIL rand_key frame=%0d got=%h exp=%h", i, kp.key, m_key); end
            total++; if (kp.key_press !== m_press) begin bad++; $display("FAIL rand_press frame=%0d got=%h exp=%h", i, kp.key_press, m_press); end
            total++; if (kp.key_release !== m_rel) begin bad++; $display("FAIL rand_release frame=%0d got=%h exp=%h", i, kp.key_release, m_rel); end
            @(negedge clk);
            total++; if ((kp.key_press | kp.key_release) !== '0) begin bad++; $display("FAIL rand_pulse_width frame=%0d got=%h/%h exp=0/0", i, kp.key_press, kp.key_release); end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        kp_keys = '0;
        m_key = '0; m_press = '0; m_rel = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_hold();
        test_bounce();
        test_release();
        test_reset_mid();
        test_ghost();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
